// File: rtl/cp0_exc_unit_if.sv
// Core <-> CP0 bus: trap/eret strobes, MFC0/MTC0 access and the redirect/status results.
interface cp0_exc_unit_if;
    logic [31:0] pc;
    logic        exception;
    logic [4:0]  cause_code;
    logic        eret;
    logic        mtc0;
    logic        mfc0;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exc_addr;
    logic [31:0] status;
    logic        timer_irq;

    modport master (
        output pc, exception, cause_code, eret, mtc0, mfc0, addr, wdata,
        input  rdata, exc_addr, status, timer_irq
    );

    modport slave (
        input  pc, exception, cause_code, eret, mtc0, mfc0, addr, wdata,
        output rdata, exc_addr, status, timer_irq
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor 0 for the single-cycle MIPS core: Status/Cause/EPC/Count/Compare,
// trap/ERET redirect target, MFC0/MTC0 access and a sticky Count==Compare interrupt.
module cp0_exc_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
    parameter int unsigned COUNT_DIV    = 2
) (
    input  logic             clk,
    input  logic             rst,
    cp0_exc_unit_if.slave    bus
);

    localparam int unsigned   PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    typedef enum logic [4:0] {
        REG_COUNT   = 5'd9,
        REG_COMPARE = 5'd11,
        REG_STATUS  = 5'd12,
        REG_CAUSE   = 5'd13,
        REG_EPC     = 5'd14
    } cp0_reg_e;

    logic [31:0]   status_q, status_d;
    logic [31:0]   epc_q, epc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    exc_code_q, exc_code_d;
    logic [1:0]    sw_ip_q, sw_ip_d;
    logic          tirq_q, tirq_d;

    logic          tick;
    logic          count_wr;
    logic          compare_wr;
    logic [31:0]   cause_rd;

    always_comb begin
        tick       = (presc_q == PRESC_MAX);
        presc_d    = tick ? '0 : presc_q + PW'(1);
        count_d    = count_q + 32'(tick);
        status_d   = status_q;
        epc_d      = epc_q;
        compare_d  = compare_q;
        exc_code_d = exc_code_q;
        sw_ip_d    = sw_ip_q;
        count_wr   = 1'b0;
        compare_wr = 1'b0;

        if (bus.exception) begin
            epc_d      = bus.pc;
            exc_code_d = bus.cause_code;
            status_d   = status_q << 5;
        end else if (bus.eret) begin
            status_d = status_q >> 5;
        end else if (bus.mtc0) begin
            case (bus.addr)
                REG_COUNT: begin
                    count_d  = bus.wdata;
                    presc_d  = '0;
                    count_wr = 1'b1;
                end
                REG_COMPARE: begin
                    compare_d  = bus.wdata;
                    compare_wr = 1'b1;
                end
                REG_STATUS: status_d = bus.wdata;
                REG_CAUSE:  sw_ip_d  = bus.wdata[9:8];
                REG_EPC:    epc_d    = bus.wdata;
                default: ;
            endcase
        end

        // Only an increment can raise the flag; a Compare write in the same edge wins.
        tirq_d = compare_wr ? 1'b0
                            : (tirq_q | (tick & ~count_wr & (count_d == compare_q)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q   <= 32'h0000_000F;
            epc_q      <= '0;
            count_q    <= '0;
            compare_q  <= '1;
            presc_q    <= '0;
            exc_code_q <= '0;
            sw_ip_q    <= '0;
            tirq_q     <= 1'b0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            presc_q    <= presc_d;
            exc_code_q <= exc_code_d;
            sw_ip_q    <= sw_ip_d;
            tirq_q     <= tirq_d;
        end
    end

    assign cause_rd = {16'b0, tirq_q, 5'b0, sw_ip_q, 1'b0, exc_code_q, 2'b0};

    always_comb begin
        bus.rdata = '0;
        if (bus.mfc0) begin
            case (bus.addr)
                REG_COUNT:   bus.rdata = count_q;
                REG_COMPARE: bus.rdata = compare_q;
                REG_STATUS:  bus.rdata = status_q;
                REG_CAUSE:   bus.rdata = cause_rd;
                REG_EPC:     bus.rdata = epc_q;
                default:     bus.rdata = '0;
            endcase
        end
    end

    assign bus.exc_addr  = bus.eret ? epc_q : HANDLER_ADDR;
    assign bus.status    = status_q;
    assign bus.timer_irq = tirq_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Randomised + directed bench for cp0_exc_unit against an architectural CP0 model.
module tb_cp0_exc_unit;

    localparam logic [31:0] HANDLER = 32'h0040_0004;
    localparam int          CDIV    = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    cp0_exc_unit_if bus ();

    cp0_exc_unit #(.HANDLER_ADDR(HANDLER), .COUNT_DIV(CDIV)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Architectural state of CP0 as the software sees it.
    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
    int          m_presc;
    bit          m_irq;

    task automatic model_reset();
        m_status = 32'h0000_000F; m_cause = 0; m_epc = 0; m_count = 0;
        m_compare = 32'hFFFF_FFFF; m_presc = 0; m_irq = 0;
    endtask

    function automatic logic [31:0] mread(logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return (m_cause & ~32'h8000) | (m_irq ? 32'h8000 : 32'h0);
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of architectural behaviour, using the inputs currently on the bus.
    task automatic model_edge();
        bit tick, cnt_written, cmp_written;
        tick        = (m_presc == CDIV - 1);
        cnt_written = 0;
        cmp_written = 0;
        m_presc     = tick ? 0 : m_presc + 1;
        if (tick) m_count = m_count + 1;
        if (bus.exception) begin
            m_epc    = bus.pc;
            m_cause  = (m_cause & ~32'h7C) | (32'(bus.cause_code) << 2);
            m_status = m_status << 5;
        end else if (bus.eret) begin
            m_status = m_status >> 5;
        end else if (bus.mtc0) begin
            case (bus.addr)
                5'd9:  begin m_count = bus.wdata; m_presc = 0; cnt_written = 1; end
                5'd11: begin m_compare = bus.wdata; cmp_written = 1; end
                5'd12: m_status = bus.wdata;
                5'd13: m_cause = (m_cause & ~32'h300) | (bus.wdata & 32'h300);
                5'd14: m_epc = bus.wdata;
                default: ;
            endcase
        end
        if (cmp_written)                                  m_irq = 0;
        else if (tick && !cnt_written && m_count == m_compare) m_irq = 1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.pc = 32'h0; bus.exception = 0; bus.cause_code = 0; bus.eret = 0;
        bus.mtc0 = 0; bus.mfc0 = 0; bus.addr = 0; bus.wdata = 0;
    endtask

    // Called at a negedge after inputs are set: let them settle and compare against the model.
    task automatic settle();
        #2;
        check("rdata",     bus.rdata,    bus.mfc0 ? mread(bus.addr) : 32'h0);
        check("exc_addr",  bus.exc_addr, bus.eret ? m_epc : HANDLER);
        check("status",    bus.status,   m_status);
        check("timer_irq", 32'(bus.timer_irq), 32'(m_irq));
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic rd(logic [4:0] a);
        idle(); bus.mfc0 = 1; bus.addr = a; settle();
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d);
        idle(); bus.mtc0 = 1; bus.addr = a; bus.wdata = d; settle(); adv();
    endtask

    task automatic wait_irq(string name);
        bit seen = 0;
        for (int k = 0; k < 64 && !seen; k++) begin
            rd(5'd9);
            if (bus.timer_irq) seen = 1;
            else adv();
        end
        if (!seen) check(name, 32'h0, 32'h1);
    endtask

    initial begin
        logic [31:0] cnt_exp [5];
        logic [31:0] pa, pb;
        cnt_exp = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2};
        pa = 32'h0040_0200;
        pb = 32'h0040_0300;

        idle();
        rst_n = 0;
        model_reset();
        repeat (3) @(negedge clk);
        settle();
        check("rst_status",   bus.status,   32'h0000_000F);
        check("rst_exc_addr", bus.exc_addr, 32'h0040_0004);
        check("rst_rdata_off", bus.rdata,   32'h0);
        rst_n = 1;

        // Count advances once every two clocks after reset release.
        for (int i = 0; i < 5; i++) begin
            rd(5'd9);
            check("count_seq", bus.rdata, cnt_exp[i]);
            adv();
        end

        // Single trap and return.
        idle(); bus.exception = 1; bus.cause_code = 5'd8; bus.pc = 32'h0040_0100; settle(); adv();
        rd(5'd14); check("epc_after_syscall", bus.rdata, 32'h0040_0100);
        check("status_after_syscall", bus.status, 32'h0000_01E0); adv();
        rd(5'd13); check("cause_code", (bus.rdata >> 2) & 32'h1F, 32'd8); adv();
        idle(); bus.eret = 1; settle();
        check("eret_target", bus.exc_addr, 32'h0040_0100); adv();
        rd(5'd12); check("status_after_eret", bus.rdata, 32'h0000_000F); adv();

        // Nested traps.
        idle(); bus.exception = 1; bus.cause_code = 5'd9;  bus.pc = pa; settle(); adv();
        idle(); bus.exception = 1; bus.cause_code = 5'd13; bus.pc = pb; settle(); adv();
        rd(5'd12); check("nested_status2", bus.rdata, 32'h0000_3C00); adv();
        idle(); bus.eret = 1; settle(); check("nested_eret1_target", bus.exc_addr, pb); adv();
        rd(5'd12); check("nested_status_pop1", bus.rdata, 32'h0000_01E0);
        idle(); bus.eret = 1; settle(); check("nested_eret2_target", bus.exc_addr, pb); adv();
        rd(5'd12); check("nested_status_pop2", bus.rdata, 32'h0000_000F); adv();

        // Timer: rise at Count==5, survive a wrap, clear on Compare write.
        wr(5'd9, 32'd0);
        wr(5'd11, 32'd5);
        wait_irq("irq_timeout_cmp5");
        check("irq_count_value", bus.rdata, 32'd5);
        check("irq_set", 32'(bus.timer_irq), 32'd1); adv();
        wr(5'd9, 32'hFFFF_FFFE);
        repeat (8) begin idle(); settle(); adv(); end
        rd(5'd9);
        check("count_wrapped", bus.rdata, 32'd2);
        check("irq_sticky_wrap", 32'(bus.timer_irq), 32'd1); adv();
        wr(5'd11, 32'h100);
        idle(); settle(); check("irq_cleared", 32'(bus.timer_irq), 32'd0); adv();

        // Priority collisions.
        idle(); bus.exception = 1; bus.cause_code = 5'd8; bus.pc = 32'h0040_0400;
        bus.mtc0 = 1; bus.addr = 5'd12; bus.wdata = 32'h1234; settle(); adv();
        rd(5'd12); check("exc_beats_mtc0", bus.rdata, 32'h0000_01E0); adv();
        idle(); bus.eret = 1; bus.mtc0 = 1; bus.addr = 5'd14; bus.wdata = 32'hDEAD_BEEF; settle();
        check("eret_old_epc", bus.exc_addr, 32'h0040_0400); adv();
        rd(5'd14); check("eret_drops_mtc0", bus.rdata, 32'h0040_0400); adv();

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            int unsigned r;
            idle();
            bus.pc         = $urandom;
            bus.exception  = ($urandom_range(0, 15) == 0);
            r              = $urandom_range(0, 2);
            bus.cause_code = (r == 0) ? 5'd8 : (r == 1) ? 5'd9 : 5'd13;
            bus.eret       = ($urandom_range(0, 15) == 0);
            bus.mtc0       = ($urandom_range(0, 4) == 0);
            bus.mfc0       = ($urandom_range(0, 1) == 0);
            r              = $urandom_range(0, 6);
            bus.addr       = (r == 0) ? 5'd9 : (r == 1) ? 5'd11 : (r == 2) ? 5'd12 :
                             (r == 3) ? 5'd13 : (r == 4) ? 5'd14 : 5'($urandom);
            case ($urandom_range(0, 3))
                0:       bus.wdata = m_count + $urandom_range(0, 6);
                1:       bus.wdata = 32'h0000_000F;
                2:       bus.wdata = m_compare - $urandom_range(0, 3);
                default: bus.wdata = $urandom;
            endcase
            settle();
            adv();
        end

        // Asynchronous reset while the timer flag is up.
        wr(5'd11, m_count + 3);
        wait_irq("irq_timeout_prereset");
        #1 rst_n = 0;
        #1;
        model_reset();
        check("async_rst_count", bus.rdata, 32'h0);
        check("async_rst_irq", 32'(bus.timer_irq), 32'd0);
        check("async_rst_status", bus.status, 32'h0000_000F);
        bus.addr = 5'd11; #1;
        check("async_rst_compare", bus.rdata, 32'hFFFF_FFFF);
        bus.addr = 5'd7; #1;
        check("unmapped_read", bus.rdata, 32'h0);
        @(negedge clk);
        idle(); settle();
        @(negedge clk);
        rst_n = 1;
        repeat (6) begin rd(5'd9); adv(); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
